// File: rtl/boot_loader.sv
// boot_loader: UART 8N1 program loader that fills RAM port A with little-endian words, then releases the cpu core.
// Optional BOOT_CHECKSUM_EN adds a trailing XOR checksum byte that must match before the core is released.
module boot_loader #(
  parameter int CLK_DIV    = 868,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  error
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {
    L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR
`ifdef BOOT_CHECKSUM_EN
    , L_CSUM
`endif
  } ld_state_t;
`ifdef BOOT_CHECKSUM_EN
  localparam ld_state_t L_FIN = L_CSUM;
`else
  localparam ld_state_t L_FIN = L_DONE;
`endif
  localparam logic [15:0] HALF    = 16'(CLK_DIV / 2);
  localparam logic [15:0] LAST    = 16'(CLK_DIV - 1);
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;
  rx_state_t           rs;
  ld_state_t           ls;
  logic                rx_s1, rx_s2, byte_valid, frame_err;
  logic [15:0]         timer, length;
  logic [2:0]          bit_cnt;
  logic [7:0]          rx_byte, len_lo;
  logic [1:0]          byte_cnt;
  logic [23:0]         word;
  logic [ADDR_WIDTH:0] word_idx;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          csum;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rs         <= R_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rs)
        R_IDLE: if (!rx_s2) begin
          rs    <= R_START;
          timer <= '0;
        end
        R_START: if (timer == HALF) begin
          timer   <= '0;
          bit_cnt <= '0;
          rs      <= rx_s2 ? R_IDLE : R_DATA;
        end else timer <= timer + 16'd1;
        R_DATA: if (timer == LAST) begin
          timer   <= '0;
          rx_byte <= {rx_s2, rx_byte[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rs <= R_STOP;
        end else timer <= timer + 16'd1;
        default: if (timer == LAST) begin
          timer      <= '0;
          byte_valid <= rx_s2;
          frame_err  <= !rx_s2;
          rs         <= R_IDLE;
        end else timer <= timer + 16'd1;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ls        <= L_LEN0;
      len_lo    <= '0;
      length    <= '0;
      byte_cnt  <= '0;
      word      <= '0;
      word_idx  <= '0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      error     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      ram_we <= '0;
      if (rs == R_IDLE && !rx_s2 && ls == L_LEN0) busy <= 1'b1;
      if (frame_err && ls != L_DONE) begin
        ls        <= L_ERR;
        error     <= 1'b1;
        cpu_reset <= 1'b1;
        busy      <= 1'b0;
      end else case (ls)
        L_LEN0: if (byte_valid) begin
          len_lo <= rx_byte;
          ls     <= L_LEN1;
        end
        L_LEN1: if (byte_valid) begin
          length <= {rx_byte, len_lo};
          if ({rx_byte, len_lo} == 16'd0) begin
            ls        <= L_FIN;
            cpu_reset <= L_FIN != L_DONE;
            busy      <= L_FIN != L_DONE;
          end else if ({1'b0, rx_byte, len_lo} > MAX_LEN) begin
            ls    <= L_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else ls <= L_DATA;
        end
        L_DATA: if (byte_valid) begin
          byte_cnt <= byte_cnt + 2'd1;
          word     <= {rx_byte, word[23:8]};
`ifdef BOOT_CHECKSUM_EN
          csum     <= csum ^ rx_byte;
`endif
          if (byte_cnt == 2'd3) begin
            ram_we    <= 4'hF;
            ram_addr  <= word_idx[ADDR_WIDTH-1:0];
            ram_wdata <= {rx_byte, word};
            word_idx  <= word_idx + 1'b1;
          end
        end else if (ram_we != 4'h0 && 16'(word_idx) == length) begin
          ls        <= L_FIN;
          cpu_reset <= L_FIN != L_DONE;
          busy      <= L_FIN != L_DONE;
        end
`ifdef BOOT_CHECKSUM_EN
        L_CSUM: if (byte_valid) begin
          ls        <= (rx_byte == csum) ? L_DONE : L_ERR;
          cpu_reset <= rx_byte != csum;
          error     <= rx_byte != csum;
          busy      <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed UART stimulus with immediate-assertion checks of boot_loader writes and status.
module tb_boot_loader;
  logic        clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic [3:0]  ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        cpu_reset, busy, error;
  int          ncmp = 0, nerr = 0, nw = 0, b;
  logic [31:0] wd [16];
  logic [8:0]  wa [16];
  logic [3:0]  wwe [16];
  logic        wcr [16];
  logic        post_cr = 1'b1, post_busy = 1'b1, after = 1'b0;
`ifdef BOOT_CHECKSUM_EN
  localparam logic CS = 1'b1;
`else
  localparam logic CS = 1'b0;
`endif

  boot_loader #(.CLK_DIV(16), .ADDR_WIDTH(9)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .cpu_reset(cpu_reset), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we != 4'h0) begin
      if (nw < 16) begin
        wd[nw]  <= ram_wdata;
        wa[nw]  <= ram_addr;
        wwe[nw] <= ram_we;
        wcr[nw] <= cpu_reset;
      end
      nw    <= nw + 1;
      after <= 1'b1;
    end else if (after) begin
      post_cr   <= cpu_reset;
      post_busy <= busy;
      after     <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1);
    rx = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(16);
    end
    rx = stop;
    idle(16);
    rx = 1'b1;
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    reset = 1'b0;
    idle(4);
  endtask

  initial begin
    do_reset();
    // 4-cycle low glitch must not produce a byte
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    b = nw;
    send_byte(8'h01);
    send_byte(8'h00);
    chk("t1_busy_mid", 32'(busy), 32'h1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    idle(4);
    chk("t1_post_cpu_reset", 32'(post_cr), 32'(CS));
    chk("t1_post_busy", 32'(post_busy), 32'(CS));
    if (CS) send_byte(8'h08);
    idle(40);
    chk("t1_nwrites", 32'(nw - b), 32'd1);
    chk("t1_addr", 32'(wa[b]), 32'h0);
    chk("t1_data", wd[b], 32'h12345678);
    chk("t1_we", 32'(wwe[b]), 32'hF);
    chk("t1_cr_during_write", 32'(wcr[b]), 32'h1);
    chk("t1_cpu_reset", 32'(cpu_reset), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_error", 32'(error), 32'h0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(40);
    chk("t1_done_ignores", 32'(nw - b), 32'd1);
    chk("t1_done_error", 32'(error), 32'h0);

    do_reset();
    b = nw;
    send_byte(8'h03); send_byte(8'h00);
    for (int i = 0; i < 12; i++) send_byte(8'(i));
    if (CS) send_byte(8'h00);
    idle(40);
    chk("t2_nwrites", 32'(nw - b), 32'd3);
    chk("t2_addr0", 32'(wa[b]), 32'd0);
    chk("t2_addr1", 32'(wa[b+1]), 32'd1);
    chk("t2_addr2", 32'(wa[b+2]), 32'd2);
    chk("t2_data0", wd[b], 32'h03020100);
    chk("t2_data1", wd[b+1], 32'h07060504);
    chk("t2_data2", wd[b+2], 32'h0B0A0908);
    chk("t2_cr_w1", 32'(wcr[b+1]), 32'h1);
    chk("t2_cr_w2", 32'(wcr[b+2]), 32'h1);
    chk("t2_cpu_reset", 32'(cpu_reset), 32'h0);

    do_reset();
    b = nw;
    send_byte(8'h00); send_byte(8'h00);
    if (CS) send_byte(8'h00);
    idle(40);
    chk("t3_cpu_reset", 32'(cpu_reset), 32'h0);
    chk("t3_busy", 32'(busy), 32'h0);
    chk("t3_nwrites", 32'(nw - b), 32'd0);

    do_reset();
    b = nw;
    send_byte(8'h01); send_byte(8'h02);
    idle(40);
    chk("t4_error", 32'(error), 32'h1);
    chk("t4_cpu_reset", 32'(cpu_reset), 32'h1);
    chk("t4_busy", 32'(busy), 32'h0);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    idle(40);
    chk("t4_nwrites", 32'(nw - b), 32'd0);
    chk("t4_error_sticky", 32'(error), 32'h1);

    do_reset();
    b = nw;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h78, 1'b0);
    idle(40);
    chk("t5_error", 32'(error), 32'h1);
    chk("t5_cpu_reset", 32'(cpu_reset), 32'h1);
    chk("t5_nwrites", 32'(nw - b), 32'd0);

    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hEF); send_byte(8'hBE);
    do_reset();
    b = nw;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    if (CS) send_byte(8'h22);
    idle(40);
    chk("t6_nwrites", 32'(nw - b), 32'd1);
    chk("t6_addr", 32'(wa[b]), 32'h0);
    chk("t6_data", wd[b], 32'hDEADBEEF);
    chk("t6_cpu_reset", 32'(cpu_reset), 32'h0);
    chk("t6_error", 32'(error), 32'h0);
    if (CS) begin
      do_reset();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      send_byte(8'h23);
      idle(40);
      chk("t6_bad_csum_error", 32'(error), 32'h1);
      chk("t6_bad_csum_cpu_reset", 32'(cpu_reset), 32'h1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Serial program loader that sits upstream of the cpu core.
- While reset is asserted and during loading, it holds the core in reset and owns RAM port A.
- It receives an 8N1 UART byte stream, assembles little-endian 32-bit words, and writes them to consecutive word addresses from 0.
- After the last word is written it releases the core.

Parameters:
CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535
ADDR_WIDTH, 9, RAM word-address width; maximum image size is 2**ADDR_WIDTH words

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  UART receive line, asynchronous to clk, idle high
ram_we  output  4  byte write enables to RAM port A
ram_addr  output  ADDR_WIDTH  RAM word address
ram_wdata  output  32  RAM write data
cpu_reset  output  1  active-high reset to the cpu core
busy  output  1  high from the first start bit until the loader reaches DONE or ERR
error  output  1  sticky error flag

Behaviour:
- Reset values: ram_we=0, ram_addr=0, ram_wdata=0, cpu_reset=1, busy=0, error=0; rx synchroniser flops=1. Reset mid-load aborts the load and returns every output to these values.
- rx input: passes through a 2-flop synchroniser before use.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: on synchronised rx=0, go to R_START and clear the bit timer.
  - R_START: at timer=CLK_DIV/2, if rx=1 treat it as a glitch and return to R_IDLE; else go to R_DATA.
  - R_DATA: sample each bit at every subsequent CLK_DIV cycles, LSB first, for 8 bits, then go to R_STOP.
  - R_STOP: sample one CLK_DIV later. If 1, pulse byte_valid for one cycle. If 0, pulse frame_err. Either way, return to R_IDLE.
- Loader FSM states: L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR.
  - L_LEN0: first byte = length[7:0].
  - L_LEN1: next byte = length[15:8], where length is the word count.
    - length=0: go to L_DONE.
    - length>2**ADDR_WIDTH: go to L_ERR.
    - otherwise: go to L_DATA.
  - L_DATA: bytes are little-endian; byte k of a word goes to bits [8k+7:8k].
    - On the 4th byte of a word, in the cycle after its byte_valid: ram_we=4'hF for exactly one cycle, ram_addr=word index, ram_wdata=assembled word.
    - After the write, the word index increments and the byte counter returns to 0.
  - End of data: the cycle after the write of word length-1, go to L_DONE.
  - L_DONE: cpu_reset=0 and busy=0. Further bytes are received but ignored; no RAM writes occur. Only reset leaves L_DONE.
  - L_ERR: error=1, cpu_reset=1, busy=0, no RAM writes. Only reset leaves L_ERR.
- Framing error: frame_err in any state other than L_DONE goes to L_ERR.
- ram_we: 0 in every cycle except the single write cycle. ram_addr/ram_wdata hold their last value between writes.
- busy: set on the first R_START entry while the loader is in L_LEN0.
- Simultaneous events: a byte_valid and a pending RAM write cannot overlap, because the minimum byte period is 10*CLK_DIV cycles.

Optional Feature:
BOOT_CHECKSUM_EN
- Defined: after the last data word, the loader enters L_CSUM and waits for one extra byte.
  - Equal to the XOR of all data bytes: go to L_DONE.
  - Mismatch: go to L_ERR.
  - For length=0 the expected checksum is 8'h00.
- Undefined: no L_CSUM state; behaviour as above.

Test Plan:
- CLK_DIV=16, send 01 00 78 56 34 12 -> one cycle with ram_we=F, ram_addr=0, ram_wdata=32'h12345678; the cycle after that write cpu_reset=0, busy=0, error=0.
- Send 03 00 followed by 12 bytes 00..0B -> writes to addr 0,1,2 of 03020100, 07060504, 0B0A0908 in order; cpu_reset stays 1 until after the third write.
- Send 00 00 -> cpu_reset=0 after the LEN1 byte with no RAM writes (with BOOT_CHECKSUM_EN, also send byte 00).
- Send 01 02 (length=513) -> error=1, cpu_reset stays 1, no writes; later bytes are ignored.
- Drive the stop bit low on the third byte -> error=1, no writes; a 4-cycle low glitch on idle rx produces no byte.
- Assert reset mid-word (after 2 data bytes), then send 01 00 EF BE AD DE -> single write addr 0 data DEADBEEF; with BOOT_CHECKSUM_EN, checksum byte 22 -> DONE and checksum 23 -> error=1.
